// File: rtl/pipe_ctrl_pkg.sv
// Shared types for the pipeline controller: register/PC widths, FSM encoding
// and the scoreboard hit rule used by every hazard port.
package pipe_ctrl_pkg;

  localparam int REG_ADDR_W  = 5;
  localparam int NUM_REGS    = 32;
  localparam int PC_W        = 32;
  localparam int OUTST_W     = 4;
  localparam int FLUSH_CNT_W = 3;

  typedef logic [REG_ADDR_W-1:0] reg_addr_t;
  typedef logic [PC_W-1:0]       pc_t;

  typedef enum logic {
    PC_RUN   = 1'b0,
    PC_FLUSH = 1'b1
  } pc_state_e;

  // A register blocks ID only while still owed; a writeback landing this cycle
  // releases it because the regfile writes through to the read port.
  function automatic logic sb_hit(input logic [NUM_REGS-1:0] pending,
                                  input reg_addr_t           addr,
                                  input logic                wb_valid,
                                  input reg_addr_t           wb_addr);
    return (addr != '0) && pending[addr] && !(wb_valid && (wb_addr == addr));
  endfunction

endpackage

// File: rtl/pipe_ctrl_if.sv
// Signal bundle between idu/EX/writeback and the pipeline controller, plus
// debug taps exposing the controller's state, outstanding count and scoreboard.
interface pipe_ctrl_if;
  import pipe_ctrl_pkg::*;

  // Handshake: id_valid_i is the ID stage's valid, issue_o is the controller's
  // ready-and-accept; the ID instruction moves to EX exactly in cycles where
  // both are high, and ID must hold it unchanged while issue_o stays low.
  logic      id_valid_i;
  reg_addr_t id_rs1_addr_i;
  logic      id_rs1_re_i;
  reg_addr_t id_rs2_addr_i;
  logic      id_rs2_re_i;
  reg_addr_t id_rd_addr_i;
  logic      id_rd_we_i;
  logic      id_long_i;
  logic      wb_valid_i;
  reg_addr_t wb_rd_addr_i;
  logic      ex_jump_i;
  pc_t       ex_jump_addr_i;

  logic      issue_o;
  logic      stall_if_o;
  logic      stall_id_o;
  logic      flush_id_o;
  logic      flush_ex_o;
  logic      jump_o;
  pc_t       jump_addr_o;

  pc_state_e                dbg_state;
  logic [OUTST_W-1:0]       dbg_outst;
  logic [NUM_REGS-1:0]      dbg_pending;

  modport master (
    output id_valid_i, id_rs1_addr_i, id_rs1_re_i, id_rs2_addr_i, id_rs2_re_i,
           id_rd_addr_i, id_rd_we_i, id_long_i, wb_valid_i, wb_rd_addr_i,
           ex_jump_i, ex_jump_addr_i,
    input  issue_o, stall_if_o, stall_id_o, flush_id_o, flush_ex_o, jump_o,
           jump_addr_o, dbg_state, dbg_outst, dbg_pending
  );

  modport slave (
    input  id_valid_i, id_rs1_addr_i, id_rs1_re_i, id_rs2_addr_i, id_rs2_re_i,
           id_rd_addr_i, id_rd_we_i, id_long_i, wb_valid_i, wb_rd_addr_i,
           ex_jump_i, ex_jump_addr_i,
    output issue_o, stall_if_o, stall_id_o, flush_id_o, flush_ex_o, jump_o,
           jump_addr_o, dbg_state, dbg_outst, dbg_pending
  );

endinterface

// File: rtl/pipe_ctrl_scoreboard.sv
// Pending-register scoreboard for long-latency ops: one bit per architectural
// register, cleared by writeback, set on issue, with three hazard lookup ports.
module pipe_ctrl_scoreboard
  import pipe_ctrl_pkg::*;
(
  input  logic                clk,
  input  logic                rst_n,
  input  logic                wb_valid,
  input  reg_addr_t           wb_addr,
  input  logic                set_en,
  input  reg_addr_t           set_addr,
  input  reg_addr_t           rs1_addr,
  input  reg_addr_t           rs2_addr,
  input  reg_addr_t           rd_addr,
  output logic                rs1_hit,
  output logic                rs2_hit,
  output logic                rd_hit,
  output logic [NUM_REGS-1:0] pending
);

  logic [NUM_REGS-1:0] pending_d;

  // Set is applied after clear so a same-cycle reissue to a just-retired
  // register keeps it owed; x0 is hardwired and never tracked.
  always_comb begin
    pending_d = pending;
    if (wb_valid) pending_d[wb_addr] = 1'b0;
    if (set_en)   pending_d[set_addr] = 1'b1;
    pending_d[0] = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) pending <= '0;
    else        pending <= pending_d;
  end

  assign rs1_hit = sb_hit(pending, rs1_addr, wb_valid, wb_addr);
  assign rs2_hit = sb_hit(pending, rs2_addr, wb_valid, wb_addr);
  assign rd_hit  = sb_hit(pending, rd_addr,  wb_valid, wb_addr);

endmodule

// File: rtl/pipe_ctrl.sv
// IF/ID/EX pipeline controller: scoreboard-driven decode stalls, outstanding
// long-op budget, and a timed IF/ID flush after an EX jump.
module pipe_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int MAX_OUTST = 4,
  parameter int FLUSH_CYC = 2
) (
  input logic       clk,
  input logic       rst_n,
  pipe_ctrl_if.slave bus
);

  localparam logic [OUTST_W-1:0]     OUTST_MAX  = OUTST_W'(MAX_OUTST);
  localparam logic [FLUSH_CNT_W-1:0] FLUSH_INIT = FLUSH_CNT_W'(FLUSH_CYC - 1);

  pc_state_e               state;
  logic [FLUSH_CNT_W-1:0]  flush_cnt;
  logic [OUTST_W-1:0]      outst;
  logic                    jump_q;
  pc_t                     jump_addr_q;
  logic [NUM_REGS-1:0]     pending;

  logic rs1_hit, rs2_hit, rd_hit;
  logic raw, waw, full, hz;
  logic in_run, jump_now, issue, set_en;
  logic outst_inc, outst_dec;

  assign set_en = issue & bus.id_long_i & bus.id_rd_we_i & (bus.id_rd_addr_i != '0);

  pipe_ctrl_scoreboard u_scoreboard (
    .clk      (clk),
    .rst_n    (rst_n),
    .wb_valid (bus.wb_valid_i),
    .wb_addr  (bus.wb_rd_addr_i),
    .set_en   (set_en),
    .set_addr (bus.id_rd_addr_i),
    .rs1_addr (bus.id_rs1_addr_i),
    .rs2_addr (bus.id_rs2_addr_i),
    .rd_addr  (bus.id_rd_addr_i),
    .rs1_hit  (rs1_hit),
    .rs2_hit  (rs2_hit),
    .rd_hit   (rd_hit),
    .pending  (pending)
  );

  assign raw  = bus.id_valid_i & ((bus.id_rs1_re_i & rs1_hit) | (bus.id_rs2_re_i & rs2_hit));
  assign waw  = bus.id_valid_i & bus.id_rd_we_i & rd_hit;
  assign full = bus.id_valid_i & bus.id_long_i & (outst == OUTST_MAX) & ~bus.wb_valid_i;
  assign hz   = raw | waw | full;

  // Outputs are gated by rst_n so an asserted reset silences them at once,
  // even while ID/EX inputs are still toggling.
  assign jump_now = rst_n & bus.ex_jump_i;
  assign in_run   = rst_n & (state == PC_RUN) & ~bus.ex_jump_i;
  assign issue    = in_run & bus.id_valid_i & ~hz;

  assign bus.issue_o     = issue;
  assign bus.stall_if_o  = in_run & hz;
  assign bus.stall_id_o  = in_run & hz;
  assign bus.flush_id_o  = jump_now | (rst_n & (state == PC_FLUSH));
  assign bus.flush_ex_o  = jump_now;
  assign bus.jump_o      = jump_q;
  assign bus.jump_addr_o = jump_addr_q;
  assign bus.dbg_state   = state;
  assign bus.dbg_outst   = outst;
  assign bus.dbg_pending = pending;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= PC_RUN;
      flush_cnt   <= '0;
      jump_q      <= 1'b0;
      jump_addr_q <= '0;
    end else begin
      jump_q <= bus.ex_jump_i;
      if (bus.ex_jump_i) begin
        state       <= PC_FLUSH;
        flush_cnt   <= FLUSH_INIT;
        jump_addr_q <= bus.ex_jump_addr_i;
      end else if (state == PC_FLUSH) begin
        if (flush_cnt == '0) state     <= PC_RUN;
        else                 flush_cnt <= flush_cnt - 1'b1;
      end
    end
  end

  // Flushes never touch outst: ops already past EX still write back.
  assign outst_inc = issue & bus.id_long_i;
  assign outst_dec = bus.wb_valid_i & (outst != '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      outst <= '0;
    end else begin
      case ({outst_inc, outst_dec})
        2'b10:   outst <= outst + 1'b1;
        2'b01:   outst <= outst - 1'b1;
        default: outst <= outst;
      endcase
    end
  end

  a_no_wb_underflow: assert property (@(posedge clk) disable iff (!rst_n)
    !(bus.wb_valid_i && (outst == '0)));

endmodule
